firebird7_in_gate1_tessent_secure_mux_ctrl: RTL and testbench

//  IJTAG-accessible controller driving the select lines of NUM_MUX secure scan muxes in firebird7_in_gate1.
//  - Select bits stay forced to 0 (mux_in0 path) until a matching key is shifted in and updated.
//  - Sits on the IJTAG network as one TDR, between the SIB and the secure scanmux instances.
//  - Exposes lock status to the security monitor.

---
 rtl/firebird7_in_gate1_secure_mux_pkg.sv | 35 +++
 rtl/firebird7_in_gate1_tessent_secure_tdr_core.sv | 54 +++++
 rtl/firebird7_in_gate1_tessent_secure_mux_ctrl.sv | 146 ++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_secure_mux_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_secure_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_secure_mux_pkg
// Purpose  : Shared types and defaults for the firebird7_in_gate1 secure scan
//            mux controller. Provides the controller state encoding, default
//            key/counter parameters and the fail-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package firebird7_in_gate1_secure_mux_pkg;

  localparam int                DEFAULT_NUM_MUX   = 4;
  localparam int                DEFAULT_KEY_WIDTH = 16;
  localparam logic [15:0]       DEFAULT_KEY_VALUE = 16'hA5C3;
  localparam int                DEFAULT_MAX_FAIL  = 3;

  // Controller state. LOCKOUT is only reachable when the lockout feature is
  // compiled in; the encoding is kept identical in both builds.
  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } secure_state_e;

  // Width needed to hold 0..max_fail inclusive, never below one bit.
  function automatic int fail_cnt_width(input int max_fail);
    int w;
    w = $clog2(max_fail + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : firebird7_in_gate1_secure_mux_pkg
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_secure_tdr_core.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_secure_tdr_core
// Purpose  : Generic W-bit IJTAG test data register. Captures a parallel
//            word, shifts LSB first toward o_so, and raises a one-cycle
//            update strobe for the owning logic to consume.
// Ports    : clk        - test clock, rising edge
//            rst_n      - asynchronous active-low reset, clears the register
//            i_sel      - register selected; qualifies all enables
//            i_ce/i_se/i_ue - capture / shift / update enables (ce > se > ue)
//            i_si       - serial input, enters at the MSB
//            i_capture  - parallel capture data
//            o_so       - serial output (register LSB)
//            o_sr       - current register contents
//            o_update   - update strobe (combinational, sampled by owner)
// Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_secure_tdr_core #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_sel,
  input  logic         i_ce,
  input  logic         i_se,
  input  logic         i_ue,
  input  logic         i_si,
  input  logic [W-1:0] i_capture,
  output logic         o_so,
  output logic [W-1:0] o_sr,
  output logic         o_update
);

  logic [W-1:0] r_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_sel) begin
      if (i_ce) begin
        r_sr <= i_capture;
      end else if (i_se) begin
        r_sr <= {i_si, r_sr[W-1:1]};
      end
    end
  end

  // Update only wins when neither capture nor shift is requested.
  assign o_update = i_sel & i_ue & ~i_ce & ~i_se;
  assign o_sr     = r_sr;
  assign o_so     = r_sr[0];

endmodule : firebird7_in_gate1_tessent_secure_tdr_core
`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_secure_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : firebird7_in_gate1_tessent_secure_mux_ctrl
// Purpose  : IJTAG-accessible key-protected controller for NUM_MUX secure
//            scan mux select lines. Select bits are held at 0 until the key
//            field of the TDR matches KEY_VALUE at an update.
//            Optional feature macro: SECURE_MUX_LOCKOUT_EN - after MAX_FAIL
//            wrong-key updates the controller enters a sticky LOCKOUT state
//            cleared only by ijtag_reset.
// Ports    : ijtag_tck   - test clock, rising edge
//            ijtag_reset - asynchronous active-low reset
//            ijtag_sel   - TDR select, qualifies ce/se/ue
//            ijtag_ce/se/ue - capture / shift / update enables
//            ijtag_si    - scan in
//            ijtag_so    - scan out (TDR LSB)
//            mux_select  - NUM_MUX secure mux select bits
//            unlocked    - high while UNLOCKED
//            lockout     - high while LOCKOUT (constant 0 without the macro)
// Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_secure_mux_ctrl
  import firebird7_in_gate1_secure_mux_pkg::*;
#(
  parameter int                   NUM_MUX   = DEFAULT_NUM_MUX,
  parameter int                   KEY_WIDTH = DEFAULT_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_VALUE = KEY_WIDTH'(DEFAULT_KEY_VALUE),
  parameter int                   MAX_FAIL  = DEFAULT_MAX_FAIL
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               ijtag_sel,
  input  logic               ijtag_ce,
  input  logic               ijtag_se,
  input  logic               ijtag_ue,
  input  logic               ijtag_si,
  output logic               ijtag_so,
  output logic [NUM_MUX-1:0] mux_select,
  output logic               unlocked,
  output logic               lockout
);

  localparam int             W          = KEY_WIDTH + NUM_MUX;
  localparam int             FCW        = fail_cnt_width(MAX_FAIL);
  localparam logic [FCW-1:0] C_FAIL_MAX = FCW'(MAX_FAIL);

  logic [W-1:0]       w_sr;
  logic [W-1:0]       w_capture;
  logic               w_update;
  logic               w_key_ok;
  logic [NUM_MUX-1:0] w_sel_field;
  logic [FCW-1:0]     w_fail_next;

  secure_state_e      r_state;
  logic [NUM_MUX-1:0] r_mux_select;
  logic               r_unlocked;
  logic [FCW-1:0]     r_fail_cnt;

  // Capture exposes only the live select bits; the key field reads as zero
  // so the key can never be recovered through the scan path.
  assign w_capture = {{KEY_WIDTH{1'b0}}, r_mux_select};

  firebird7_in_gate1_tessent_secure_tdr_core #(
    .W (W)
  ) u_tdr (
    .clk       (ijtag_tck),
    .rst_n     (ijtag_reset),
    .i_sel     (ijtag_sel),
    .i_ce      (ijtag_ce),
    .i_se      (ijtag_se),
    .i_ue      (ijtag_ue),
    .i_si      (ijtag_si),
    .i_capture (w_capture),
    .o_so      (ijtag_so),
    .o_sr      (w_sr),
    .o_update  (w_update)
  );

  assign w_key_ok    = (w_sr[W-1:NUM_MUX] == KEY_VALUE);
  assign w_sel_field = w_sr[NUM_MUX-1:0];
  // Saturating increment: the counter parks at MAX_FAIL and never wraps.
  assign w_fail_next = (r_fail_cnt == C_FAIL_MAX) ? r_fail_cnt
                                                  : r_fail_cnt + FCW'(1);

`ifdef SECURE_MUX_LOCKOUT_EN
  logic r_lockout;
`endif

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_state      <= ST_LOCKED;
      r_mux_select <= '0;
      r_unlocked   <= 1'b0;
      r_fail_cnt   <= '0;
`ifdef SECURE_MUX_LOCKOUT_EN
      r_lockout    <= 1'b0;
`endif
    end else if (w_update) begin
      case (r_state)
        ST_LOCKED, ST_UNLOCKED: begin
          if (w_key_ok) begin
            r_state      <= ST_UNLOCKED;
            r_mux_select <= w_sel_field;
            r_unlocked   <= 1'b1;
            // Only a fresh unlock forgives earlier failures.
            if (r_state == ST_LOCKED) begin
              r_fail_cnt <= '0;
            end
          end else begin
            // Wrong key always relocks and parks the muxes on input 0.
            r_state      <= ST_LOCKED;
            r_mux_select <= '0;
            r_unlocked   <= 1'b0;
            r_fail_cnt   <= w_fail_next;
`ifdef SECURE_MUX_LOCKOUT_EN
            if (w_fail_next == C_FAIL_MAX) begin
              r_state   <= ST_LOCKOUT;
              r_lockout <= 1'b1;
            end
`endif
          end
        end
        ST_LOCKOUT: begin
          // Sticky: every update is ignored until reset.
          r_mux_select <= '0;
          r_unlocked   <= 1'b0;
        end
        default: begin
          r_state      <= ST_LOCKED;
          r_mux_select <= '0;
          r_unlocked   <= 1'b0;
        end
      endcase
    end
  end

  assign mux_select = r_mux_select;
  assign unlocked   = r_unlocked;

`ifdef SECURE_MUX_LOCKOUT_EN
  assign lockout = r_lockout;
`else
  assign lockout = 1'b0;
`endif

endmodule : firebird7_in_gate1_tessent_secure_mux_ctrl
`default_nettype wire

// File: tb/tb_firebird7_in_gate1_tessent_secure_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_firebird7_in_gate1_tessent_secure_mux_ctrl
// Purpose  : Directed self-checking bench for the secure scan mux controller
//            at default parameters (NUM_MUX=4, KEY=16'hA5C3, W=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_firebird7_in_gate1_tessent_secure_mux_ctrl;

  localparam int          W   = 20;
  localparam logic [15:0] KEY = 16'hA5C3;

  logic       clk;
  logic       rst_n;
  logic       sel, ce, se, ue, si;
  logic       so;
  logic [3:0] mux_select;
  logic       unlocked;
  logic       lockout;

  int n_checks;
  int n_errors;

  firebird7_in_gate1_tessent_secure_mux_ctrl dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .ijtag_sel   (sel),
    .ijtag_ce    (ce),
    .ijtag_se    (se),
    .ijtag_ue    (ue),
    .ijtag_si    (si),
    .ijtag_so    (so),
    .mux_select  (mux_select),
    .unlocked    (unlocked),
    .lockout     (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [W-1:0] din, output logic [W-1:0] dout);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < W; i++) begin
      si      = din[i];
      dout[i] = so;
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic capture();
    sel = 1'b1;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
  endtask

  task automatic update();
    sel = 1'b1;
    ue  = 1'b1;
    tick();
    ue  = 1'b0;
  endtask

  task automatic load_and_update(input logic [15:0] key, input logic [3:0] s);
    logic [W-1:0] dummy;
    shift_word({key, s}, dummy);
    update();
  endtask

  task automatic read_back(output logic [W-1:0] dout);
    capture();
    shift_word('0, dout);
  endtask

  logic [W-1:0] rd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    #12;
    check("rst_mux", 32'(mux_select), 32'h0);
    check("rst_unlocked", 32'(unlocked), 32'h0);
    check("rst_lockout", 32'(lockout), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: capture in LOCKED reads all zero
    read_back(rd);
    check("t1_readback", 32'(rd), 32'h0);
    check("t1_mux", 32'(mux_select), 32'h0);
    check("t1_unlocked", 32'(unlocked), 32'h0);

    // 2: correct key unlocks; readback shows only the select bits
    load_and_update(KEY, 4'hA);
    check("t2_mux", 32'(mux_select), 32'hA);
    check("t2_unlocked", 32'(unlocked), 32'h1);
    read_back(rd);
    check("t2_readback", 32'(rd), 32'h0000A);
    check("t2_mux_after_shift", 32'(mux_select), 32'hA);

    // 3: wrong key from UNLOCKED relocks and counts a failure
    load_and_update(16'h1234, 4'hF);
    check("t3_mux", 32'(mux_select), 32'h0);
    check("t3_unlocked", 32'(unlocked), 32'h0);
    check("t3_fail_cnt", 32'(dut.r_fail_cnt), 32'h1);

    // 4: ce+se+ue together -> capture only; sel=0 holds everything
    load_and_update(KEY, 4'h5);
    check("t4_mux_unlock", 32'(mux_select), 32'h5);
    check("t4_fail_clr", 32'(dut.r_fail_cnt), 32'h0);
    shift_word({KEY, 4'h3}, rd);
    sel = 1'b1; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    check("t4_prio_mux", 32'(mux_select), 32'h5);
    shift_word({KEY, 4'h9}, rd);
    check("t4_prio_captured", 32'(rd), 32'h00005);
    sel = 1'b0; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    tick(); tick(); tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    check("t4_nosel_mux", 32'(mux_select), 32'h5);
    update();
    check("t4_nosel_sr_held", 32'(mux_select), 32'h9);

    // 5: repeated wrong keys
    load_and_update(16'h0000, 4'h1);
    load_and_update(16'hFFFF, 4'h2);
    load_and_update(16'h5A3C, 4'h3);
    check("t5_fail_sat", 32'(dut.r_fail_cnt), 32'h3);
    check("t5_mux", 32'(mux_select), 32'h0);
`ifdef SECURE_MUX_LOCKOUT_EN
    check("t5_lockout", 32'(lockout), 32'h1);
    load_and_update(KEY, 4'h5);
    check("t5_locked_mux", 32'(mux_select), 32'h0);
    check("t5_locked_unl", 32'(unlocked), 32'h0);
    check("t5_locked_sticky", 32'(lockout), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_reset_clears", 32'(lockout), 32'h0);
    rst_n = 1'b1;
    tick();
`else
    check("t5_no_lockout", 32'(lockout), 32'h0);
    load_and_update(16'h0001, 4'h4);
    check("t5_fail_no_wrap", 32'(dut.r_fail_cnt), 32'h3);
    load_and_update(KEY, 4'h5);
    check("t5_retry_mux", 32'(mux_select), 32'h5);
    check("t5_retry_unl", 32'(unlocked), 32'h1);
    check("t5_retry_fail_clr", 32'(dut.r_fail_cnt), 32'h0);
`endif

    // 6: asynchronous reset in the middle of a shift
    load_and_update(KEY, 4'hC);
    check("t6_pre_mux", 32'(mux_select), 32'hC);
    sel = 1'b1; se = 1'b1; si = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6_pre_so", 32'(so), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_mux", 32'(mux_select), 32'h0);
    check("t6_unlocked", 32'(unlocked), 32'h0);
    check("t6_lockout", 32'(lockout), 32'h0);
    check("t6_so", 32'(so), 32'h0);
    check("t6_sr", 32'(dut.u_tdr.r_sr), 32'h0);
    check("t6_state", 32'(dut.r_state), 32'h0);
    se = 1'b0; si = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    read_back(rd);
    check("t6_readback", 32'(rd), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_firebird7_in_gate1_tessent_secure_mux_ctrl
`default_nettype wire
